// File: rtl/lampfpu_rnd_pack_pkg.sv
// lampFPU_pkg: shared rounding-mode enum, flag indices, special-value constants
// and the combinational bfloat16 round-and-pack function.
`default_nettype none

package lampFPU_pkg;

  typedef enum logic [1:0] {
    RNE = 2'd0,
    RTZ = 2'd1,
    RDN = 2'd2,
    RUP = 2'd3
  } rndMode_t;

  localparam int FLAG_NX = 0;
  localparam int FLAG_UF = 1;
  localparam int FLAG_OF = 2;

  localparam logic [7:0] EXP_MAX_FIN  = 8'hFE;
  localparam logic [6:0] FRAC_MAX_FIN = 7'h7F;
  localparam logic [7:0] EXP_INF      = 8'hFF;
  localparam logic [6:0] FRAC_INF     = 7'h00;

  typedef struct packed {
    logic [15:0] result;
    logic [2:0]  flags;
  } rndPack_t;

  // f = {0, hidden, frac[6:0], G, R, S}
  function automatic rndPack_t FUNC_rndPack(
    input logic       s,
    input logic [7:0] e,
    input logic [11:0] f,
    input rndMode_t   mode,
    input logic       isOvf,
    input logic       isUnf
  );
    rndPack_t   res;
    logic       lsb, x, inc, ovf, nx, toInf;
    logic [8:0] sum;
    logic [8:0] expR;
    logic [6:0] fracR;

    lsb = f[3];
    x   = f[2] | f[1] | f[0];
    case (mode)
      RNE:     inc = f[2] & (f[1] | f[0] | lsb);
      RTZ:     inc = 1'b0;
      RDN:     inc = s & x;
      default: inc = ~s & x;
    endcase

    sum = {1'b0, f[10:3]} + {8'd0, inc};
    if (sum[8]) begin
      expR  = {1'b0, e} + 9'd1;
      fracR = 7'd0;
    end else if ((e == 8'd0) && sum[7]) begin
      expR  = 9'd1;
      fracR = sum[6:0];
    end else begin
      expR  = {1'b0, e};
      fracR = sum[6:0];
    end

    ovf   = isOvf | (expR >= 9'h0FF);
    nx    = x | ovf;
    toInf = (mode == RNE) | ((mode == RUP) & ~s) | ((mode == RDN) & s);

    if (ovf)
      res.result = toInf ? {s, EXP_INF, FRAC_INF} : {s, EXP_MAX_FIN, FRAC_MAX_FIN};
    else
      res.result = {s, expR[7:0], fracR};

    res.flags          = 3'b000;
    res.flags[FLAG_OF] = ovf;
    res.flags[FLAG_NX] = nx;
    res.flags[FLAG_UF] = isUnf | ((expR == 9'd0) & nx);
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lampfpu_rnd_pack_if.sv
// Upstream/downstream handshake bundle of the round-and-pack stage.
`default_nettype none

interface lampfpu_rnd_pack_if;
  logic        valid_i;
  logic        ready_o;
  logic        s_i;
  logic [7:0]  e_i;
  logic [11:0] f_i;
  logic        isToRound_i;
  logic        isOverflow_i;
  logic        isUnderflow_i;
  logic [1:0]  rndMode_i;
  logic        clrFlags_i;
  logic        valid_o;
  logic        ready_i;
  logic [15:0] result_o;
  logic [2:0]  fflags_o;

  modport slave (
    input  valid_i, s_i, e_i, f_i, isToRound_i, isOverflow_i, isUnderflow_i,
           rndMode_i, clrFlags_i, ready_i,
    output ready_o, valid_o, result_o, fflags_o
  );

  modport master (
    output valid_i, s_i, e_i, f_i, isToRound_i, isOverflow_i, isUnderflow_i,
           rndMode_i, clrFlags_i, ready_i,
    input  ready_o, valid_o, result_o, fflags_o
  );
endinterface

`default_nettype wire

// File: rtl/lampfpu_rnd_pack_sync_fifo.sv
// lampfpu_sync_fifo: valid/ready FIFO; output forced to zero while empty.
`default_nettype none

module lampfpu_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             push_i,
  input  wire logic [WIDTH-1:0] data_i,
  output logic                  ready_o,
  output logic                  valid_o,
  input  wire logic             pop_i,
  output logic [WIDTH-1:0]      data_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, rdPtr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             doPush, doPop;

  assign ready_o = (count_q < CW'(DEPTH));
  assign valid_o = (count_q != '0);
  assign doPush  = push_i & ready_o;
  assign doPop   = pop_i & valid_o;
  assign data_o  = valid_o ? mem_q[rdPtr_q] : '0;

  always_comb begin
    count_d = count_q;
    case ({doPush, doPop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset: entries are only observable when counted.
  always_ff @(posedge clk) begin
    if (doPush)
      mem_q[wrPtr_q] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      count_q <= count_d;
      if (doPush)
        wrPtr_q <= wrPtr_q + AW'(1);
      if (doPop)
        rdPtr_q <= rdPtr_q + AW'(1);
    end
  end
endmodule

`default_nettype wire

// File: rtl/lampfpu_rnd_pack.sv
// lampfpu_rnd_pack: rounds/packs an unrounded bfloat16 result and buffers it,
// accumulating sticky {OF, UF, NX} flags at push time.
`default_nettype none

module lampfpu_rnd_pack
  import lampFPU_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  wire logic         clk,
  input  wire logic         rst,
  lampfpu_rnd_pack_if.slave io
);
  rndPack_t    rp;
  logic        push;
  logic [15:0] wdata;
  logic [2:0]  pushFlags;
  logic [2:0]  fflags_q, fflags_d;
  logic        unused_fTop;

  assign unused_fTop = io.f_i[11];

  assign rp = FUNC_rndPack(io.s_i, io.e_i, io.f_i, rndMode_t'(io.rndMode_i),
                           io.isOverflow_i, io.isUnderflow_i);

  assign push      = io.valid_i & io.ready_o;
  assign wdata     = io.isToRound_i ? rp.result : {io.s_i, io.e_i, io.f_i[9:3]};
  assign pushFlags = (push & io.isToRound_i) ? rp.flags : 3'b000;

  // Clear happens before the OR so flags of a same-cycle push survive.
  always_comb begin
    fflags_d = io.clrFlags_i ? 3'b000 : fflags_q;
    fflags_d = fflags_d | pushFlags;
  end

  always_ff @(posedge clk) begin
    if (rst)
      fflags_q <= 3'b000;
    else
      fflags_q <= fflags_d;
  end

  assign io.fflags_o = fflags_q;

  lampfpu_sync_fifo #(
    .WIDTH (16),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (io.valid_i),
    .data_i  (wdata),
    .ready_o (io.ready_o),
    .valid_o (io.valid_o),
    .pop_i   (io.ready_i),
    .data_o  (io.result_o)
  );
endmodule

`default_nettype wire

// File: doc/lampfpu_rnd_pack.md
LAMPFPU_RND_PACK -- requirements
Module: lampfpu_rnd_pack

Interface
REQ-001 SHALL have parameter DEPTH, default 2, output buffer entries (power of two, >=2).
REQ-002 SHALL have clk  input  1  clock; all state on rising edge.
REQ-003 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have valid_i  input  1  unrounded result present.
REQ-005 SHALL have ready_o  output  1  block can accept this cycle.
REQ-006 SHALL have s_i  input  1  sign.
REQ-007 SHALL have e_i  input  8  biased exponent.
REQ-008 SHALL have f_i  input  12  unrounded fraction: [11]=0, [10]=hidden, [9:3]=frac, [2]=G, [1]=R, [0]=S.
REQ-009 SHALL have isToRound_i, isOverflow_i, isUnderflow_i  input  1 each  status from arithmetic unit.
REQ-010 SHALL have rndMode_i  input  2  0=RNE, 1=RTZ, 2=RDN, 3=RUP.
REQ-011 SHALL have clrFlags_i  input  1  clear sticky flags.
REQ-012 SHALL have valid_o  output  1  packed result present.
REQ-013 SHALL have ready_i  input  1  consumer accepts.
REQ-014 SHALL have result_o  output  16  packed bfloat16 {s, e[7:0], frac[6:0]}.
REQ-015 SHALL have fflags_o  output  3  sticky {OF, UF, NX}.

Function
REQ-016 Push SHALL occur when valid_i && ready_o; pop SHALL occur when valid_o && ready_i.
REQ-017 ready_o SHALL be 1 iff buffer count < DEPTH, from registered count only (no combinational path from ready_i).
REQ-018 A pushed result SHALL be visible on result_o the next cycle when the buffer was empty; latency is 1 cycle.
REQ-019 Results SHALL leave in acceptance order. Simultaneous push and pop SHALL leave count unchanged. Pointers SHALL wrap modulo DEPTH.
REQ-020 valid_o SHALL be 1 iff count != 0. result_o SHALL be stable while valid_o && !ready_i.
REQ-021 isToRound_i=0: result SHALL be {s_i, e_i, f_i[9:3]} unmodified, with no flag update.
REQ-022 Rounding increment inc SHALL be set per mode, with L=f_i[3] and X=G|R|S:
  - RNE: G&(R|S|L)
  - RTZ: 0
  - RDN: s_i&X
  - RUP: ~s_i&X
REQ-023 Mantissa rounding SHALL compute sum[8:0] = f_i[10:3] + inc.
  - sum[8]=1: exponent = e_i+1, frac = 0.
  - e_i=0 and sum[7]=1: exponent = 1 (subnormal promotion).
  - Otherwise: exponent = e_i, frac = sum[6:0].
REQ-024 Overflow SHALL be isOverflow_i, or a rounded exponent of 0xFF.
  - On overflow, result SHALL be Inf (e=0xFF, frac=0) for RNE; RUP with s=0; RDN with s=1.
  - Otherwise result SHALL be max finite (e=0xFE, frac=0x7F), sign kept.
REQ-025 Flags on rounded push:
  - NX = X|OF.
  - OF = overflow.
  - UF = isUnderflow_i | (rounded exponent==0 & NX).
REQ-026 fflags_o SHALL be OR-accumulated at push. clrFlags_i SHALL clear before OR, so the same-cycle push flags survive.
REQ-027 Rounding logic SHALL be combinational on inputs. The buffer write SHALL be the only pipeline register.

Reset
REQ-028 rst SHALL clear count, rd/wr pointers and fflags_o.
  - valid_o=0, result_o=0, ready_o=1 the cycle after rst.
REQ-029 rst mid-transfer SHALL discard buffered results; the same-cycle push SHALL be ignored.

Structure
REQ-030 The rounding-mode enum (RNE/RTZ/RDN/RUP), flag bit indices, max-finite and Inf constants SHALL live in lampFPU_pkg.
REQ-031 Rounding/packing SHALL be a package function FUNC_rndPack(s, e, f, mode) returning {result, flags}.
REQ-032 Buffering SHALL be one sub-module lampfpu_sync_fifo, parameterised on width and DEPTH.

Verification
REQ-033 RNE tie-even: s=0, e=0x7F, f=0x404 -> result 0x3F80, NX=1. Then f=0x40C -> 0x3F82.
REQ-034 Carry: e=0x7F, f=0x7FC, RNE -> 0x4000, NX=1, OF=0.
REQ-035 Overflow: e=0xFE, f=0x7FC. RNE -> 0x7F80, flags OF|NX. RTZ -> 0x7F7F. RDN with s=1 -> 0xFF80.
REQ-036 Backpressure: ready_i=0, DEPTH=2, three back-to-back valid_i -> ready_o=0 after two pushes, third held. Then ready_i=1 -> three results in order, no loss or duplication.
REQ-037 Passthrough: isToRound_i=0, s=0, e=0xFF, f=0x600 -> 0x7FC0, fflags unchanged.
REQ-038 Clear/reset: clrFlags_i with a same-cycle NX push -> fflags_o=NX only. rst with 2 entries buffered -> valid_o=0, fflags_o=0 next cycle.
